// File: rtl/banco_registros_sb.sv
// Purpose : register file (2 combinational read ports, 1 write port) with a per-register busy scoreboard.
// Latency : reads and busy flags are combinational; writes, busy bits and busy_count update on the rising edge.
// Backpressure: none; the decode stage uses busy1/busy2 to stall on RAW hazards.
//
// Ports:
//   clk, rsta                  clock, asynchronous active-low reset
//   read_reg1/2 -> read_data1/2, busy1/2   combinational read of data and busy flag
//   RegWrite, write_reg, write_data        writeback (stores data, clears busy)
//   issue_valid, issue_rd                  issue (marks destination busy)
//   busy_count                             registered population count of busy bits
//
// Optional macro BANCO_REGISTROS_BYPASS_EN: same-cycle write-through of writeback data
// and busy clear onto the read ports.
module banco_registros_sb #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rsta,
  input  logic [AW-1:0]   read_reg1,
  input  logic [AW-1:0]   read_reg2,
  output logic [XLEN-1:0] read_data1,
  output logic [XLEN-1:0] read_data2,
  output logic            busy1,
  output logic            busy2,
  input  logic            RegWrite,
  input  logic [AW-1:0]   write_reg,
  input  logic [XLEN-1:0] write_data,
  input  logic            issue_valid,
  input  logic [AW-1:0]   issue_rd,
  output logic [AW:0]     busy_count
);

  localparam bit ZR = (ZERO_REG != 0);

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;
  logic [AW:0]      busy_count_q;
  logic [AW:0]      busy_count_d;

  logic wr_en;
  logic iss_en;
  logic cnt_inc;
  logic cnt_dec;

  // Register 0 is invisible to both write and issue when it is hardwired.
  assign wr_en  = RegWrite    && !(ZR && (write_reg == '0));
  assign iss_en = issue_valid && !(ZR && (issue_rd  == '0));

  // Clear for writeback first, then set for issue, so a same-cycle issue wins.
  always_comb begin
    busy_d = busy_q;
    if (wr_en)  busy_d[write_reg] = 1'b0;
    if (iss_en) busy_d[issue_rd]  = 1'b1;
  end

  // Incremental count: a set only counts if the bit was clear; a clear only
  // counts if the bit was set and is not re-claimed by an issue this cycle.
  assign cnt_inc = iss_en && !busy_q[issue_rd];
  assign cnt_dec = wr_en && busy_q[write_reg] && !(iss_en && (issue_rd == write_reg));

  always_comb begin
    busy_count_d = busy_count_q + (AW+1)'(cnt_inc) - (AW+1)'(cnt_dec);
  end

  always_ff @(posedge clk or negedge rsta) begin
    if (!rsta) begin
      busy_q       <= '0;
      busy_count_q <= '0;
    end else begin
      busy_q       <= busy_d;
      busy_count_q <= busy_count_d;
    end
  end

  always_ff @(posedge clk or negedge rsta) begin
    if (!rsta) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en) begin
      regs_q[write_reg] <= write_data;
    end
  end

  assign busy_count = busy_count_q;

  // Read port 1
  always_comb begin
    read_data1 = regs_q[read_reg1];
    busy1      = busy_q[read_reg1];
`ifdef BANCO_REGISTROS_BYPASS_EN
    // Bypass is suppressed while reset is held so outputs read 0 during reset.
    if (rsta && wr_en && (write_reg == read_reg1)) begin
      read_data1 = write_data;
      busy1      = iss_en && (issue_rd == read_reg1);
    end
`endif
    if (ZR && (read_reg1 == '0)) begin
      read_data1 = '0;
      busy1      = 1'b0;
    end
  end

  // Read port 2
  always_comb begin
    read_data2 = regs_q[read_reg2];
    busy2      = busy_q[read_reg2];
`ifdef BANCO_REGISTROS_BYPASS_EN
    if (rsta && wr_en && (write_reg == read_reg2)) begin
      read_data2 = write_data;
      busy2      = iss_en && (issue_rd == read_reg2);
    end
`endif
    if (ZR && (read_reg2 == '0)) begin
      read_data2 = '0;
      busy2      = 1'b0;
    end
  end

endmodule

// File: doc/banco_registros_sb.md
Name: banco_registros_sb

Overview:
- Parametrised successor to the RV32I register file (banco_registros): 2 combinational read ports, 1 synchronous write port.
- Adds a per-register busy scoreboard: the issue stage marks rd busy, writeback clears it, and decode uses the busy flags to stall on RAW hazards.
- Sits between decode (reads, issue) and writeback (write) in the pipelined core.

Parameters:
- XLEN, 32, data width of each register.
- NREGS, 32, number of architectural registers; power of two, 2..64.
- ZERO_REG, 1, 1 = register 0 hardwired to zero and never busy; 0 = register 0 is an ordinary register.
- Localparam AW = $clog2(NREGS); not overridable.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rsta  in  1  asynchronous, active-low reset.
- read_reg1  in  AW  port-1 read address.
- read_reg2  in  AW  port-2 read address.
- read_data1  out  XLEN  port-1 data, combinational.
- read_data2  out  XLEN  port-2 data, combinational.
- busy1  out  1  busy flag of read_reg1, combinational.
- busy2  out  1  busy flag of read_reg2, combinational.
- RegWrite  in  1  writeback enable.
- write_reg  in  AW  writeback destination.
- write_data  in  XLEN  writeback data.
- issue_valid  in  1  an instruction with a destination issues this cycle.
- issue_rd  in  AW  destination of the issuing instruction.
- busy_count  out  AW+1  number of registers currently busy.

Behaviour:
- Reset:
  - rsta low clears all registers to 0, all busy bits to 0 and busy_count to 0, immediately and independent of clk.
  - Outputs then read 0 / not busy.
  - Reset asserted mid-operation discards any pending write or issue in that cycle.
- Write:
  - On the rising edge with RegWrite=1, reg[write_reg] <= write_data.
  - With ZERO_REG=1, writes to address 0 are ignored.
- Read:
  - read_dataN = reg[read_regN]; zero-latency combinational path.
  - With ZERO_REG=1, address 0 always returns 0.
- Scoreboard, evaluated per rising edge:
  - issue_valid=1, issue_rd=r: busy[r] <= 1.
  - RegWrite=1, write_reg=w: busy[w] <= 0.
  - Same register issued and written in the same cycle: issue wins, busy stays 1 (a new producer replaces the old one).
  - Write to a non-busy register: data is written, busy stays 0, no error.
  - Issue to an already-busy register: busy stays 1, busy_count unchanged.
  - ZERO_REG=1: issue and write to register 0 never change busy[0]; busy[0] is constant 0.
- busy_count:
  - Registered; equals the population count of the busy bits after each edge.
  - Maintained incrementally: +1 on a 0->1 transition, -1 on a 1->0 transition.
  - Both transitions in the same cycle (different registers) leave it unchanged.
  - Never exceeds NREGS (NREGS-1 when ZERO_REG=1).
- busyN = busy[read_regN] at the current state.
- Out-of-range addresses cannot occur: NREGS is a power of two.

Optional Feature:
- Macro: BANCO_REGISTROS_BYPASS_EN.
- Defined: write-through bypass.
  - If RegWrite=1 and write_reg==read_regN (and nonzero when ZERO_REG=1), read_dataN = write_data in the same cycle.
  - busyN reads 0 for that register unless issue_valid=1 with issue_rd==read_regN in the same cycle.
- Not defined: reads return the pre-edge register contents and the pre-edge busy flag.
  - Decode sees the written value one cycle after writeback.

Test Plan:
- Reset check: pulse rsta low between clock edges -> every read_data = 0, busy1 = busy2 = 0, busy_count = 0, with no clock edge required.
- Basic write/read: write reg1=32'hFF, then reg2=32'hAA, then read_reg1=1, read_reg2=2 -> read_data1 = 32'hFF, read_data2 = 32'hAA.
- Zero register (ZERO_REG=1):
  - Write reg0=32'hDEADBEEF and issue rd=0 -> read_data1 = 0 at addr 0, busy1 = 0, busy_count = 0.
  - With ZERO_REG=0 -> reads 32'hDEADBEEF.
- Scoreboard lifecycle:
  - Issue rd=5 -> busy1 = 1 at addr 5, busy_count = 1.
  - Issue rd=6 -> busy_count = 2.
  - Write reg5=32'h1234 -> busy(5) = 0, busy_count = 1, read_data1 = 32'h1234.
- Simultaneous events:
  - Same cycle, issue rd=7 and write reg7=32'h55 -> busy(7) = 1, data = 32'h55.
  - Same cycle, issue rd=8 and write reg6 -> busy_count unchanged.
- Bypass: same-cycle write reg3=32'hCAFE with read_reg1=3 (old value 32'h0):
  - BANCO_REGISTROS_BYPASS_EN defined -> read_data1 = 32'hCAFE before the edge.
  - Not defined -> 32'h0 before the edge, 32'hCAFE after.
